wmem_arbiter: RTL and testbench
===============================

# wmem_arbiter

Round-robin arbiter that shares the single-port weight SRAM between the conv-layer engines, FC engines and the weight-update engine of the CNN training datapath. Each requester asks for one burst of consecutive weight addresses, read or write. The arbiter grants one requester at a time, drives the SRAM port for the whole burst, returns read data and pulses a per-requester done. It sits between the top-level training controller's engines and the weight memory.

## Interface
- NUM_REQ, 4, number of requesters (2..8); index NUM_REQ-1 is the weight-update engine
- ADDR_W, 12, SRAM address width
- DATA_W, 16, SRAM data width
- LEN_W, 8, burst-length field width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  burst request per requester, level, held until done
- req_we  in  NUM_REQ  1 = write burst, 0 = read burst
- req_addr  in  NUM_REQ*ADDR_W  burst base address, requester i at [i*ADDR_W +: ADDR_W]
- req_len  in  NUM_REQ*LEN_W  beats in burst; 0 treated as 1
- req_wdata  in  NUM_REQ*DATA_W  write data of the current beat, slice per requester
- gnt  out  NUM_REQ  one-hot; high for the granted requester during BURST; each gnt cycle consumes one beat
- rd_valid  out  NUM_REQ  one-hot; read beat returned on rd_data
- rd_data  out  DATA_W  registered copy of mem_rdata
- done  out  NUM_REQ  one-cycle pulse at burst completion
- mem_en, mem_we  out  1  SRAM enable and write strobe
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE: if any req is high, select a winner and latch its we, addr and len into internal registers. The next state is BURST with gnt[winner]=1. Otherwise stay in IDLE.
- Round-robin: the search starts at rr_ptr+1 mod NUM_REQ. rr_ptr is set to the winner on each grant. The reset value of rr_ptr is NUM_REQ-1, so requester 0 wins first.
- BURST: one beat per cycle with no stall.
  - Drive mem_en=1, mem_we=latched we, mem_addr=base+beat (mod 2^ADDR_W, wraps silently).
  - mem_wdata is a combinational mux of req_wdata[winner].
  - Beat counter width is LEN_W. After the last beat (beat==len-1), go to DRAIN.
- DRAIN: gnt=0, mem_en=0, done[winner]=1 for exactly one cycle, then go to IDLE.
- Read path: rd_data <= mem_rdata and rd_valid <= one-hot winner, each one cycle after the SRAM data cycle. The last read beat therefore appears one cycle after DRAIN. Write bursts never assert rd_valid.
- Requests are sampled only in IDLE. A req change during BURST or DRAIN is ignored. Deasserting req mid-burst does not abort the burst.
- Requester contract: req must be low, or hold a new request, in the cycle after done.
- Reset, asynchronous and at any time including mid-burst:
  - state=IDLE, rr_ptr=NUM_REQ-1.
  - All outputs 0: gnt, rd_valid, rd_data, done, mem_en, mem_we, mem_addr, mem_wdata.
  - Any burst in progress is lost with no done.

## Timing
- Grant latency: req high in cycle t (state IDLE) gives gnt and the first mem_en in cycle t+1.
- A burst of L beats: gnt and mem_en are high in cycles t+1..t+L, done in t+L+1, IDLE in t+L+2.
- Read data for the beat issued in cycle c: mem_rdata is valid in c+1, and rd_valid/rd_data are registered and valid in c+2.
- Back-to-back grants: the next gnt rises at the earliest in cycle t+L+3 (2 idle cycles between bursts).
- All outputs are registered except mem_wdata.

## Configuration
- WMEM_ARB_UPDATE_PRIO_EN defined: requester NUM_REQ-1 (weight update) wins in IDLE whenever its req is high, regardless of rr_ptr. rr_ptr is not updated on such a grant. The other requesters keep round-robin order among themselves.
- Undefined: pure round-robin over all NUM_REQ requesters.

## Test plan
- Single read: req[0], addr=0x010, len=3 → gnt[0] for 3 cycles, mem_addr 0x010/0x011/0x012, rd_valid[0] 3 beats with SRAM contents, done[0] once.
- Round-robin: req[0..3] all held with len=1 → grant order 0,1,2,3,0; every gnt is one-hot with ≥2-cycle gaps.
- Write with wrap: req[2] we=1, addr=0xFFE, len=4, wdata 0xA0..0xA3 → writes to 0xFFE, 0xFFF, 0x000, 0x001; no rd_valid.
- len=0: req[1] len=0 → exactly one beat, done[1] in the cycle after.
- Priority macro: req[1] and req[3] high with rr_ptr=0. Defined → 3 wins first. Undefined → 1 wins first.
- Reset mid-burst: assert reset_n=0 on beat 2 of a len=8 burst → all outputs 0 immediately, no done. After release, req[0] is granted first.

Source files
------------

// File: rtl/wmem_arbiter_if.sv
// rtl/wmem_arbiter_if.sv - requester and SRAM signal bundle for the weight-memory arbiter
interface wmem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]        done;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport master (
        output req, req_we, req_addr, req_len, req_wdata, mem_rdata,
        input  gnt, rd_valid, rd_data, done, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, req_we, req_addr, req_len, req_wdata, mem_rdata,
        output gnt, rd_valid, rd_data, done, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/wmem_arbiter.sv
// rtl/wmem_arbiter.sv - round-robin burst arbiter for the single-port weight SRAM
// Optional WMEM_ARB_UPDATE_PRIO_EN: requester NUM_REQ-1 (weight update) always wins when requesting.
module wmem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8
) (
    input logic          clk,
    input logic          reset_n,
    wmem_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [LEN_W-1:0]     last_q, last_d;
    logic [LEN_W-1:0]     beat_q, beat_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   rd_pend_q, rd_pend_d;
    logic [NUM_REQ-1:0]   rd_valid_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;

    logic [IDX_W-1:0]     pick, sel;
    logic                 pick_found;
    logic [LEN_W-1:0]     len_sel;
    logic [ADDR_W-1:0]    addr_a  [NUM_REQ];
    logic [LEN_W-1:0]     len_a   [NUM_REQ];
    logic [DATA_W-1:0]    wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign len_a[g]   = bus.req_len[g*LEN_W +: LEN_W];
        assign wdata_a[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    // First requester found walking forward from the one after the last winner.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && bus.req[IDX_W'(idx)]) begin
                pick       = IDX_W'(idx);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        we_d       = we_q;
        base_d     = base_q;
        last_d     = last_q;
        beat_d     = beat_q;
        gnt_d      = '0;
        done_d     = '0;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        sel        = pick;
        len_sel    = '0;
        rd_pend_d  = (mem_en_q && !mem_we_q) ? gnt_q : '0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
`ifdef WMEM_ARB_UPDATE_PRIO_EN
                    if (bus.req[NUM_REQ-1]) begin
                        sel = IDX_W'(NUM_REQ - 1);
                    end else begin
                        rr_ptr_d = pick;
                    end
`else
                    rr_ptr_d = pick;
`endif
                    len_sel    = len_a[sel];
                    state_d    = BURST;
                    win_d      = sel;
                    we_d       = bus.req_we[sel];
                    base_d     = addr_a[sel];
                    last_d     = (len_sel == '0) ? '0 : len_sel - LEN_W'(1);
                    beat_d     = '0;
                    gnt_d      = NUM_REQ'(1) << sel;
                    mem_en_d   = 1'b1;
                    mem_we_d   = bus.req_we[sel];
                    mem_addr_d = addr_a[sel];
                end
            end
            BURST: begin
                if (beat_q == last_q) begin
                    state_d = DRAIN;
                    done_d  = NUM_REQ'(1) << win_q;
                end else begin
                    beat_d     = beat_q + LEN_W'(1);
                    gnt_d      = gnt_q;
                    mem_en_d   = 1'b1;
                    mem_we_d   = we_q;
                    mem_addr_d = base_q + ADDR_W'(beat_d);
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            base_q     <= '0;
            last_q     <= '0;
            beat_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rd_pend_q  <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            we_q       <= we_d;
            base_q     <= base_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_pend_q;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            // Hold the last returned beat so rd_data only moves with rd_valid.
            if (|rd_pend_q) rd_data_q <= bus.mem_rdata;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = (state_q == BURST) ? wdata_a[win_q] : '0;
endmodule

// File: tb/tb_wmem_arbiter.sv
// tb/tb_wmem_arbiter.sv - scoreboard bench for wmem_arbiter
module tb_wmem_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int LEN_W   = 8;
    localparam int IDX_W   = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   sb_on   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wmem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    wmem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [NUM_REQ-1:0] t_req = '0;
    logic [NUM_REQ-1:0] t_we  = '0;
    logic [ADDR_W-1:0]  t_addr  [NUM_REQ];
    logic [LEN_W-1:0]   t_len   [NUM_REQ];
    logic [DATA_W-1:0]  t_wdata [NUM_REQ];
    logic [DATA_W-1:0]  wbase   [NUM_REQ];
    logic [DATA_W-1:0]  sram    [1<<ADDR_W];
    logic [DATA_W-1:0]  exp_mem [1<<ADDR_W];

    assign bus.req    = t_req;
    assign bus.req_we = t_we;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign bus.req_addr[g*ADDR_W +: ADDR_W]  = t_addr[g];
        assign bus.req_len[g*LEN_W +: LEN_W]     = t_len[g];
        assign bus.req_wdata[g*DATA_W +: DATA_W] = t_wdata[g];
    end

    typedef struct {
        int                idx;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } beat_t;
    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } rd_t;

    beat_t exp_beat_q [$];
    rd_t   exp_rd_q   [$];
    int    exp_done_q [$];

    function automatic logic [DATA_W-1:0] init_val(input int a);
        logic [ADDR_W-1:0] aa;
        aa = ADDR_W'(a);
        return {4'hC, aa};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},       bus.gnt, 0);
        check({tag, "_rd_valid"},  bus.rd_valid, 0);
        check({tag, "_rd_data"},   bus.rd_data, 0);
        check({tag, "_done"},      bus.done, 0);
        check({tag, "_mem_en"},    bus.mem_en, 0);
        check({tag, "_mem_we"},    bus.mem_we, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic expect_burst(input int idx, input bit we, input logic [ADDR_W-1:0] addr,
                                input int len, input logic [DATA_W-1:0] wb);
        int n;
        n = (len == 0) ? 1 : len;
        for (int b = 0; b < n; b++) begin
            beat_t e;
            rd_t   r;
            e.idx   = idx;
            e.we    = we;
            e.addr  = addr + ADDR_W'(b);
            e.wdata = wb + DATA_W'(b);
            exp_beat_q.push_back(e);
            if (we) begin
                exp_mem[e.addr] = e.wdata;
            end else begin
                r.idx  = idx;
                r.data = exp_mem[e.addr];
                exp_rd_q.push_back(r);
            end
        end
        exp_done_q.push_back(idx);
    endtask

    task automatic drive_req(input int idx, input bit we, input logic [ADDR_W-1:0] addr,
                             input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] wb);
        t_we[IDX_W'(idx)]  = we;
        t_addr[idx]        = addr;
        t_len[idx]         = len;
        wbase[idx]         = wb;
        t_req[IDX_W'(idx)] = 1'b1;
    endtask

    // Drops each requester on its done unless it is the one re-arming for another burst.
    task automatic serve(input int ndone, input int rearm_idx);
        int got;
        int rearm_left;
        got        = 0;
        rearm_left = (rearm_idx >= 0) ? 1 : 0;
        for (int c = 0; c < 300 && got < ndone; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.done[i]) begin
                    got++;
                    if (i == rearm_idx && rearm_left > 0) rearm_left--;
                    else t_req[IDX_W'(i)] = 1'b0;
                end
            end
        end
        check("done_count", got, ndone);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic              en, we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bus.mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = init_val(i);
        forever begin
            @(posedge clk);
            en = bus.mem_en;
            we = bus.mem_we;
            a  = bus.mem_addr;
            d  = bus.mem_wdata;
            #1;
            if (en && we) sram[a] = d;
            else if (en) bus.mem_rdata = sram[a];
        end
    end

    initial begin
        int wbeat [NUM_REQ];
        for (int i = 0; i < NUM_REQ; i++) begin
            t_wdata[i] = '0;
            wbeat[i]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.gnt[i]) begin
                    t_wdata[i] = wbase[i] + DATA_W'(wbeat[i]);
                    wbeat[i]++;
                end else begin
                    wbeat[i] = 0;
                end
            end
        end
    end

    int                 last_gnt_cyc = -100;
    logic [NUM_REQ-1:0] prev_gnt     = '0;

    always @(negedge clk) begin
        beat_t e;
        rd_t   r;
        int    di;
        if (sb_on && reset_n) begin
            if (bus.gnt != '0) begin
                check("gnt_onehot", 32'($onehot(bus.gnt)), 1);
                check("mem_en_with_gnt", bus.mem_en, 1);
                if (prev_gnt == '0) check("gnt_gap_ge3", 32'((cyc - last_gnt_cyc) >= 3), 1);
                if (exp_beat_q.size() == 0) begin
                    check("unexpected_gnt", bus.gnt, 0);
                end else begin
                    e = exp_beat_q.pop_front();
                    check("gnt", bus.gnt, NUM_REQ'(1) << e.idx);
                    check("mem_we", bus.mem_we, e.we);
                    check("mem_addr", bus.mem_addr, e.addr);
                    if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
                end
                last_gnt_cyc = cyc;
            end else begin
                check("mem_en_idle", bus.mem_en, 0);
            end
            if (bus.rd_valid != '0) begin
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_rd_valid", bus.rd_valid, 0);
                end else begin
                    r = exp_rd_q.pop_front();
                    check("rd_valid", bus.rd_valid, NUM_REQ'(1) << r.idx);
                    check("rd_data", bus.rd_data, r.data);
                end
            end
            if (bus.done != '0) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", bus.done, 0);
                end else begin
                    di = exp_done_q.pop_front();
                    check("done", bus.done, NUM_REQ'(1) << di);
                    check("done_timing", cyc, last_gnt_cyc + 1);
                end
            end
        end
        prev_gnt = bus.gnt;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        int w;
        for (int i = 0; i < NUM_REQ; i++) begin
            t_addr[i] = '0;
            t_len[i]  = '0;
            wbase[i]  = '0;
        end
        for (int i = 0; i < (1 << ADDR_W); i++) exp_mem[i] = init_val(i);

        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset_n = 1'b1;
        sb_on   = 1'b1;
        @(negedge clk);

        // single read of three beats
        expect_burst(0, 1'b0, 12'h010, 3, 16'h0);
        drive_req(0, 1'b0, 12'h010, 8'd3, 16'h0);
        @(negedge clk);
        check("gnt_latency", bus.gnt, 4'b0001);
        check("first_mem_addr", bus.mem_addr, 12'h010);
        serve(1, -1);

        // len=0 behaves as one beat
        expect_burst(1, 1'b0, 12'h030, 0, 16'h0);
        drive_req(1, 1'b0, 12'h030, 8'd0, 16'h0);
        serve(1, -1);

        // write burst wrapping past the top of the address space
        expect_burst(2, 1'b1, 12'hFFE, 4, 16'h00A0);
        drive_req(2, 1'b1, 12'hFFE, 8'd4, 16'h00A0);
        serve(1, -1);

        // read back across the wrap point
        expect_burst(3, 1'b0, 12'hFFF, 2, 16'h0);
        drive_req(3, 1'b0, 12'hFFF, 8'd2, 16'h0);
        serve(1, -1);

        // all requesters held, requester 0 asks twice
`ifdef WMEM_ARB_UPDATE_PRIO_EN
        order = '{3, 0, 1, 2, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < 5; k++)
            expect_burst(order[k], 1'b0, 12'h020 + ADDR_W'(order[k]), 1, 16'h0);
        for (int i = 0; i < NUM_REQ; i++)
            drive_req(i, 1'b0, 12'h020 + ADDR_W'(i), 8'd1, 16'h0);
        serve(5, 0);

        // requesters 1 and 3 together with rr_ptr at 0
`ifdef WMEM_ARB_UPDATE_PRIO_EN
        expect_burst(3, 1'b0, 12'h043, 1, 16'h0);
        expect_burst(1, 1'b0, 12'h041, 1, 16'h0);
`else
        expect_burst(1, 1'b0, 12'h041, 1, 16'h0);
        expect_burst(3, 1'b0, 12'h043, 1, 16'h0);
`endif
        drive_req(1, 1'b0, 12'h041, 8'd1, 16'h0);
        drive_req(3, 1'b0, 12'h043, 8'd1, 16'h0);
        serve(2, -1);

        // asynchronous reset on beat 2 of an 8-beat burst
        check("sb_beats_left", exp_beat_q.size(), 0);
        sb_on = 1'b0;
        drive_req(0, 1'b0, 12'h080, 8'd8, 16'h0);
        w = 0;
        while (!bus.gnt[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_burst_started", bus.gnt, 4'b0001);
        @(negedge clk);
        check("rst_beat2_addr", bus.mem_addr, 12'h081);
        reset_n = 1'b0;
        t_req   = '0;
        #1;
        check_quiet("rst_async");
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", bus.done, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("rst_release");
        sb_on = 1'b1;
        expect_burst(0, 1'b0, 12'h090, 2, 16'h0);
        expect_burst(2, 1'b0, 12'h092, 2, 16'h0);
        drive_req(0, 1'b0, 12'h090, 8'd2, 16'h0);
        drive_req(2, 1'b0, 12'h092, 8'd2, 16'h0);
        serve(2, -1);

        check("end_beats_left", exp_beat_q.size(), 0);
        check("end_reads_left", exp_rd_q.size(), 0);
        check("end_dones_left", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
